// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator that produces the pixel coordinate bus plus sync,
// active and frame-start flags, all registered together so they describe the same pixel.
module vga_sync_gen #(
    parameter int   H_VIS  = 1280,
    parameter int   H_FP   = 48,
    parameter int   H_SYNC = 112,
    parameter int   H_BP   = 248,
    parameter int   V_VIS  = 1024,
    parameter int   V_FP   = 1,
    parameter int   V_SYNC = 3,
    parameter int   V_BP   = 38,
    parameter logic HS_POL = 1'b1,
    parameter logic VS_POL = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        CE,
    output logic [11:0] VGA_horzCoord,
    output logic [11:0] VGA_vertCoord,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_ACTIVE,
    output logic        FRAME_START
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    // 13-bit bounds so a sync window ending exactly at 4096 still compares correctly
    localparam logic [12:0] H_VIS_B = 13'(H_VIS);
    localparam logic [12:0] HS_BEG  = 13'(H_VIS + H_FP);
    localparam logic [12:0] HS_END  = 13'(H_VIS + H_FP + H_SYNC);
    localparam logic [12:0] V_VIS_B = 13'(V_VIS);
    localparam logic [12:0] VS_BEG  = 13'(V_VIS + V_FP);
    localparam logic [12:0] VS_END  = 13'(V_VIS + V_FP + V_SYNC);

    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_range_err
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 4096");
    end

    logic        h_wrap;
    logic [11:0] h_nxt;
    logic [11:0] v_nxt;
    logic        hs_nxt;
    logic        vs_nxt;
    logic        active_nxt;
    logic        fs_nxt;

    // Flags are derived from the next position so they land on the same edge as the coordinates
    always_comb begin
        h_wrap     = VGA_horzCoord == H_LAST;
        h_nxt      = h_wrap ? 12'd0 : VGA_horzCoord + 12'd1;
        v_nxt      = !h_wrap ? VGA_vertCoord :
                     (VGA_vertCoord == V_LAST) ? 12'd0 : VGA_vertCoord + 12'd1;
        hs_nxt     = ({1'b0, h_nxt} >= HS_BEG && {1'b0, h_nxt} < HS_END) ? HS_POL : ~HS_POL;
        vs_nxt     = ({1'b0, v_nxt} >= VS_BEG && {1'b0, v_nxt} < VS_END) ? VS_POL : ~VS_POL;
        active_nxt = ({1'b0, h_nxt} < H_VIS_B) && ({1'b0, v_nxt} < V_VIS_B);
        fs_nxt     = (h_nxt == 12'd0) && (v_nxt == 12'd0);
    end

    // Reset parks on the last blanking pixel so the first advance lands on (0,0)
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            VGA_horzCoord <= H_LAST;
            VGA_vertCoord <= V_LAST;
            VGA_HS        <= ~HS_POL;
            VGA_VS        <= ~VS_POL;
            VGA_ACTIVE    <= 1'b0;
            FRAME_START   <= 1'b0;
        end else if (CE) begin
            VGA_horzCoord <= h_nxt;
            VGA_vertCoord <= v_nxt;
            VGA_HS        <= hs_nxt;
            VGA_VS        <= vs_nxt;
            VGA_ACTIVE    <= active_nxt;
            FRAME_START   <= fs_nxt;
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of default, small-raster and 640x480 instances
// sharing one clock, reset and enable.
module tb_vga_sync_gen;
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic CE = 1'b0;

    logic [11:0] d_h, d_v, s_h, s_v, g_h, g_v;
    logic d_hs, d_vs, d_act, d_fs;
    logic s_hs, s_vs, s_act, s_fs;
    logic g_hs, g_vs, g_act, g_fs;

    always #5 CLK = ~CLK;

    vga_sync_gen u_def (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE),
        .VGA_horzCoord(d_h), .VGA_vertCoord(d_v),
        .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_ACTIVE(d_act), .FRAME_START(d_fs)
    );

    // 8 x 7 raster: HS active high at h=5..6, VS active low at v=4..5
    vga_sync_gen #(
        .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) u_small (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE),
        .VGA_horzCoord(s_h), .VGA_vertCoord(s_v),
        .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_ACTIVE(s_act), .FRAME_START(s_fs)
    );

    vga_sync_gen #(
        .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_VIS(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_vga (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE),
        .VGA_horzCoord(g_h), .VGA_vertCoord(g_v),
        .VGA_HS(g_hs), .VGA_VS(g_vs), .VGA_ACTIVE(g_act), .FRAME_START(g_fs)
    );

    typedef struct {
        int n;
        int h;
        int v;
        int hs;
        int vs;
        int act;
        int fs;
    } vec_t;

    vec_t tbl[10];
    int total = 0;
    int passed = 0;
    int n = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s (n=%0d): got %0d, expected %0d", nm, n, act, exp);
    endtask

    task automatic tick(input logic c);
        CE = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_def(input string nm, input int h, input int v, input int hs,
                           input int vs, input int act, input int fs);
        chk({nm, ".h"}, 32'(d_h), h);
        chk({nm, ".v"}, 32'(d_v), v);
        chk({nm, ".hs"}, 32'(d_hs), hs);
        chk({nm, ".vs"}, 32'(d_vs), vs);
        chk({nm, ".act"}, 32'(d_act), act);
        chk({nm, ".fs"}, 32'(d_fs), fs);
    endtask

    // Expected values for the small and 640x480 rasters derived from the advance count
    task automatic side_checks();
        int p, h, v;
        p = n - 1;
        if (n <= 113) begin
            h = p % 8;
            v = (p / 8) % 7;
            chk("small.h", 32'(s_h), h);
            chk("small.v", 32'(s_v), v);
            chk("small.hs", 32'(s_hs), (h >= 5 && h < 7) ? 1 : 0);
            chk("small.vs", 32'(s_vs), (v >= 4 && v < 6) ? 0 : 1);
            chk("small.act", 32'(s_act), (h < 4 && v < 3) ? 1 : 0);
            chk("small.fs", 32'(s_fs), (h == 0 && v == 0) ? 1 : 0);
        end
        if (n <= 1600) begin
            h = p % 800;
            v = p / 800;
            chk("vga.h", 32'(g_h), h);
            chk("vga.v", 32'(g_v), v);
            chk("vga.hs", 32'(g_hs), (h >= 656 && h < 752) ? 0 : 1);
        end
    endtask

    task automatic adv();
        tick(1'b1);
        n++;
        side_checks();
    endtask

    initial begin
        tbl[0] = '{1280, 1279, 0, 0, 0, 1, 0};
        tbl[1] = '{1281, 1280, 0, 0, 0, 0, 0};
        tbl[2] = '{1328, 1327, 0, 0, 0, 0, 0};
        tbl[3] = '{1329, 1328, 0, 1, 0, 0, 0};
        tbl[4] = '{1440, 1439, 0, 1, 0, 0, 0};
        tbl[5] = '{1441, 1440, 0, 0, 0, 0, 0};
        tbl[6] = '{1688, 1687, 0, 0, 0, 0, 0};
        tbl[7] = '{1689, 0, 1, 0, 0, 1, 0};
        tbl[8] = '{10128, 1687, 5, 0, 0, 0, 0};
        tbl[9] = '{10129, 0, 6, 0, 0, 1, 0};

        repeat (3) tick(1'b1);
        chk_def("reset", 1687, 1065, 0, 0, 0, 0);
        chk("reset.small.h", 32'(s_h), 7);
        chk("reset.small.vs", 32'(s_vs), 1);
        chk("reset.vga.h", 32'(g_h), 799);
        chk("reset.vga.v", 32'(g_v), 524);
        chk("reset.vga.hs", 32'(g_hs), 1);

        RESET_N = 1'b1;
        tick(1'b0);
        chk_def("idle_after_reset", 1687, 1065, 0, 0, 0, 0);

        // CE every third clock: FRAME_START must persist across the idle clocks
        adv();
        chk_def("first_adv", 0, 0, 0, 0, 1, 1);
        tick(1'b0);
        chk_def("ce_hold1", 0, 0, 0, 0, 1, 1);
        tick(1'b0);
        chk_def("ce_hold2", 0, 0, 0, 0, 1, 1);
        adv();
        chk_def("second_adv", 1, 0, 0, 0, 1, 0);
        tick(1'b0);
        tick(1'b0);
        chk_def("ce_hold3", 1, 0, 0, 0, 1, 0);

        for (int i = 0; i < 10; i++) begin
            while (n < tbl[i].n) adv();
            chk_def($sformatf("tbl%0d", i), tbl[i].h, tbl[i].v, tbl[i].hs,
                    tbl[i].vs, tbl[i].act, tbl[i].fs);
        end

        while (n < 10629) adv();
        chk("pre_reset.h", 32'(d_h), 500);
        chk("pre_reset.v", 32'(d_v), 6);
        #2;
        RESET_N = 1'b0;
        #1;
        chk_def("async_reset", 1687, 1065, 0, 0, 0, 0);
        chk("async_reset.small.h", 32'(s_h), 7);
        chk("async_reset.small.v", 32'(s_v), 6);
        tick(1'b1);
        chk_def("held_in_reset", 1687, 1065, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
